// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus datapath control unit.
// Contents: FSM state enum, 5-bit ALU opcode constants, IR field bit
// positions and an opcode classifier used by the sequencer.
// Config macro: MULDIV_EN -- when defined MUL/DIV classify as legal
// two-result operations; otherwise they classify as illegal.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ILLEGAL,
    C_BINARY,
    C_UNARY,
    C_MULDIV,
    C_NOP,
    C_HALT
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned IR_OP_MSB = 31;
  localparam int unsigned IR_OP_LSB = 27;
  localparam int unsigned IR_RA_MSB = 26;
  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_MSB = 22;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_MSB = 18;
  localparam int unsigned IR_RC_LSB = 15;

  function automatic op_class_t classify_op(input logic [4:0] op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        c = C_BINARY;
      OP_NEG, OP_NOT:                         c = C_UNARY;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV:                         c = C_MULDIV;
`endif
      OP_NOP:                                 c = C_NOP;
      OP_HALT:                                c = C_HALT;
      default:                                c = C_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Converts a 4-bit register index plus enable into a one-hot select.
// Ports:
//   i_idx    : register number
//   i_en     : when 0 the output is all-zero
//   o_onehot : NUM_REGS-wide one-hot (bit n selects Rn); indices at or
//              beyond NUM_REGS produce all-zero
module reg_select_decoder #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [3:0]          i_idx,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (i_en && (32'(i_idx) == i)) o_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit for the single-bus datapath. Sequences the
// instruction fetch (T0-T2) and execution (T3-T5, T6 for MUL/DIV) of
// register-register ALU instructions, decoding op/Ra/Rb/Rc from the
// datapath IR. All strobes are a Moore decode of state and ir; at most
// one bus driver is active in any state.
// Config macro: MULDIV_EN -- enables MUL/DIV (T6, LO/HI loads). When
// undefined MUL/DIV halt as illegal and HI_enable/LO_enable are tied 0.
// Ports:
//   clk, clr (sync active-high), run (level, stops at instr boundary)
//   ir          : IR contents, valid from T3
//   *_out       : bus drive strobes; *_enable : register loads
//   IncPC, Read : ALU increment select / memory read
//   R_out, R_enable : one-hot general register drive / load
//   opcode      : ALU operation, non-zero only in T4
//   halted, illegal : sticky status, cleared by clr
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic [31:0]         ir,
  output logic                PC_out,
  output logic                ZLow_out,
  output logic                ZHigh_out,
  output logic                MDR_out,
  output logic                MAR_enable,
  output logic                PC_enable,
  output logic                MDR_enable,
  output logic                IR_enable,
  output logic                Y_enable,
  output logic                Z_enable,
  output logic                HI_enable,
  output logic                LO_enable,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] R_out,
  output logic [NUM_REGS-1:0] R_enable,
  output logic [4:0]          opcode,
  output logic                halted,
  output logic                illegal
);

  localparam logic [3:0] W_INIT = 4'(MEM_WAIT);

  state_t     r_state;
  logic [3:0] r_wait;
  logic       r_halted;
  logic       r_illegal;

  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  op_class_t  w_class;
  logic [3:0] w_rout_idx;
  logic       w_rout_en;
  logic       w_ren_en;
  state_t     w_eoi_state;
  logic       w_unused_ir;

  assign w_op        = ir[IR_OP_MSB:IR_OP_LSB];
  assign w_ra        = ir[IR_RA_MSB:IR_RA_LSB];
  assign w_rb        = ir[IR_RB_MSB:IR_RB_LSB];
  assign w_rc        = ir[IR_RC_MSB:IR_RC_LSB];
  assign w_class     = classify_op(w_op);
  assign w_eoi_state = run ? S_T0 : S_IDLE;
  assign w_unused_ir = &{1'b0, ir[IR_RC_LSB-1:0]};

  assign halted  = r_halted;
  assign illegal = r_illegal;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (run) r_state <= S_T0;
        S_T0: begin
          r_state <= S_T1;
          r_wait  <= W_INIT;
        end
        // T1 lasts W_INIT+1 cycles: leave once the counter has hit zero
        S_T1: begin
          if (r_wait == '0) r_state <= S_T2;
          else              r_wait  <= r_wait - 4'd1;
        end
        S_T2: r_state <= S_T3;
        S_T3: begin
          case (w_class)
            C_HALT: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            C_ILLEGAL: begin
              r_state   <= S_HALT;
              r_halted  <= 1'b1;
              r_illegal <= 1'b1;
            end
            C_NOP:   r_state <= w_eoi_state;
            default: r_state <= S_T4;
          endcase
        end
        S_T4: r_state <= S_T5;
        S_T5: r_state <= (w_class == C_MULDIV) ? S_T6 : w_eoi_state;
        S_T6: r_state <= w_eoi_state;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PC_out     = 1'b0;
    ZLow_out   = 1'b0;
    ZHigh_out  = 1'b0;
    MDR_out    = 1'b0;
    MAR_enable = 1'b0;
    PC_enable  = 1'b0;
    MDR_enable = 1'b0;
    IR_enable  = 1'b0;
    Y_enable   = 1'b0;
    Z_enable   = 1'b0;
    HI_enable  = 1'b0;
    LO_enable  = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    opcode     = '0;
    w_rout_idx = '0;
    w_rout_en  = 1'b0;
    w_ren_en   = 1'b0;
    case (r_state)
      S_T0: begin
        PC_out     = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        Z_enable   = 1'b1;
      end
      S_T1: begin
        ZLow_out   = 1'b1;
        PC_enable  = (r_wait == W_INIT);
        Read       = 1'b1;
        MDR_enable = 1'b1;
      end
      S_T2: begin
        MDR_out   = 1'b1;
        IR_enable = 1'b1;
      end
      S_T3: begin
        if (w_class == C_BINARY || w_class == C_MULDIV) begin
          w_rout_idx = w_rb;
          w_rout_en  = 1'b1;
          Y_enable   = 1'b1;
        end
      end
      S_T4: begin
        if (w_class == C_BINARY || w_class == C_MULDIV) begin
          w_rout_idx = w_rc;
          w_rout_en  = 1'b1;
          opcode     = w_op;
          Z_enable   = 1'b1;
        end else if (w_class == C_UNARY) begin
          w_rout_idx = w_rb;
          w_rout_en  = 1'b1;
          opcode     = w_op;
          Z_enable   = 1'b1;
        end
      end
      S_T5: begin
        ZLow_out = 1'b1;
`ifdef MULDIV_EN
        if (w_class == C_MULDIV) LO_enable = 1'b1;
        else                     w_ren_en  = 1'b1;
`else
        w_ren_en = 1'b1;
`endif
      end
`ifdef MULDIV_EN
      S_T6: begin
        ZHigh_out = 1'b1;
        HI_enable = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .i_idx    (w_rout_idx),
    .i_en     (w_rout_en),
    .o_onehot (R_out)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_ren_dec (
    .i_idx    (w_ra),
    .i_en     (w_ren_en),
    .o_onehot (R_enable)
  );

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
Hardwired control unit for the 3-bus-less single-bus datapath; sits directly upstream of Datapath and drives its control inputs. It sequences fetch (T0–T2) and execution (T3–T5/T6) for register-register ALU instructions. It decodes the instruction from the datapath's IR output and emits one-hot register strobes plus the ALU opcode, replacing hand-driven bench FSMs.

Parameters:
MEM_WAIT, 0, extra cycles T1 is held so memory can return data (0..15)
NUM_REGS, 16, general registers; width of one-hot R_out/R_enable

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
run  in  1  level; 1 = fetch/execute, 0 = stop at next instruction boundary
ir  in  32  datapath IR contents; [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
PC_out, ZLow_out, ZHigh_out, MDR_out  out  1 each  bus drive strobes
MAR_enable, PC_enable, MDR_enable, IR_enable, Y_enable, Z_enable, HI_enable, LO_enable  out  1 each  register loads
IncPC, Read  out  1 each  ALU increment select / memory read
R_out  out  NUM_REGS  one-hot register bus drive (bit n -> Rn_out)
R_enable  out  NUM_REGS  one-hot register load (bit n -> Rn_enable)
opcode  out  5  ALU operation select
halted  out  1  sticky, in HALT state
illegal  out  1  sticky, halted on an undefined opcode

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; state register updates on posedge clk; all outputs are a combinational decode of state and ir (Moore), never two bus drivers active together.
- clr=1 at an edge -> IDLE next cycle, wait counter 0, halted=illegal=0, all outputs 0. This applies from any state, including mid-instruction and HALT.
- IDLE: all outputs 0; run=1 -> T0.
- T0: PC_out, MAR_enable, IncPC, Z_enable -> T1.
- T1: ZLow_out, PC_enable (first T1 cycle only), Read, MDR_enable. Held MEM_WAIT+1 cycles via down-counter, then -> T2.
- T2: MDR_out, IR_enable -> T3. ir is valid from T3 onward.
- Decode in T3: HALT op -> HALT, halted=1. NOP -> end-of-instruction. Undefined op -> HALT, halted=illegal=1, no strobes in that cycle.
- Binary ops (ADD SUB AND OR SHR SHRA SHL ROR ROL):
  - T3: R_out[Rb], Y_enable.
  - T4: R_out[Rc], opcode=op, Z_enable.
  - T5: ZLow_out, R_enable[Ra].
- Unary ops (NEG NOT):
  - T3: no strobes.
  - T4: R_out[Rb], opcode=op, Z_enable.
  - T5: ZLow_out, R_enable[Ra].
- End-of-instruction: after T5 (or after T3 for NOP), go to T0 if run=1, else IDLE. Dropping run mid-instruction never truncates the instruction.
- opcode = 0 outside T4. R_enable/R_out are all-zero except in the states listed above.

Optional Feature:
MULDIV_EN defined: MUL and DIV are legal.
- T3: R_out[Rb], Y_enable.
- T4: R_out[Rc], opcode, Z_enable.
- T5: ZLow_out, LO_enable.
- T6: ZHigh_out, HI_enable, then end-of-instruction.
- Ra is ignored.
Not defined: MUL/DIV decode as illegal; T6 and the HI_enable/LO_enable drivers are tied 0 (ports kept).

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum.
  - opcode constants: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010, NOP 11010, HALT 11011.
  - IR field bit positions.
- One sub-module: reg_select_decoder (4-bit index + enable -> NUM_REGS one-hot), instantiated for R_out and R_enable.

Test Plan:
- OR ir=0x30918000, MEM_WAIT=0, run=1:
  - T3: R_out=0x0004, Y_enable=1.
  - T4: R_out=0x0008, opcode=00110, Z_enable=1.
  - T5: ZLow_out=1, R_enable=0x0002.
  - With Datapath and R2=0x12, R3=0x14: R1=0x16.
- MEM_WAIT=2: Read and MDR_enable high for exactly 3 cycles; PC_enable high in only the first of them.
- NOT ir=0x90900000:
  - T3: all strobes 0.
  - T4: R_out=0x0004, opcode=10010.
  - T5: R_enable=0x0002.
- ir=0xF8000000 (undefined op 11111): halted=1 and illegal=1 from the cycle after T3; stays in HALT with run=1 until clr.
- MUL ir=0x78118000 with MULDIV_EN:
  - T5: LO_enable=1.
  - T6: ZHigh_out=1, HI_enable=1.
  - Without MULDIV_EN: illegal=1.
- clr pulsed for one cycle during T4: next cycle state IDLE, all outputs 0; with run=1, T0 follows one cycle later.
